// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared decode constants and multiply/divide FSM states
package mips_pkg;

   localparam logic [1:0] ALU_OP_RTYPE = 2'd2;

   localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
   localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
   localparam logic [5:0] FUNCT_MULT  = 6'b011000;
   localparam logic [5:0] FUNCT_MULTU = 6'b011001;
   localparam logic [5:0] FUNCT_DIV   = 6'b011010;
   localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MUL,
      ST_DIV,
      ST_FIX
   } md_state_t;

endpackage

// File: rtl/muldiv_sign_fix.sv
// rtl/muldiv_sign_fix.sv - conditional two's-complement negate, used for abs and sign restore
module muldiv_sign_fix #(
   parameter int N = 32
) (
   input  logic [N-1:0] val,
   input  logic         neg,
   output logic [N-1:0] res
);

   assign res = neg ? (N'(0) - val) : val;

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative HI/LO multiply/divide unit with mfhi/mflo read port
module muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       alu_op,
   input  logic [5:0]       funct,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             stall,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] mf_data
);

   import mips_pkg::*;

   md_state_t        state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] acc, qreg, mcand;
   logic [WIDTH-1:0] hi_r, lo_r;
   logic             neg_res, neg_rem, is_div, done_r;

   logic is_rtype, dec_mul, dec_div, dec_mfhi, dec_mflo;
   logic op_signed, a_neg, b_neg, b_zero, last_step;
   logic start_mul, start_div;
   logic [WIDTH-1:0] abs_a, abs_b;

   assign is_rtype  = (alu_op == ALU_OP_RTYPE);
   assign dec_mul   = is_rtype && (funct == FUNCT_MULT || funct == FUNCT_MULTU);
   assign dec_div   = is_rtype && (funct == FUNCT_DIV  || funct == FUNCT_DIVU);
   assign dec_mfhi  = is_rtype && (funct == FUNCT_MFHI);
   assign dec_mflo  = is_rtype && (funct == FUNCT_MFLO);
   // funct[0] distinguishes the unsigned variant in both mult and div pairs
   assign op_signed = ~funct[0];
   assign a_neg     = op_signed & op_a[WIDTH-1];
   assign b_neg     = op_signed & op_b[WIDTH-1];
   assign b_zero    = (op_b == '0);
   assign start_mul = (state == ST_IDLE) && dec_mul;
   assign start_div = (state == ST_IDLE) && dec_div;
   assign last_step = (cnt == CNT_W'(WIDTH - 1));

   muldiv_sign_fix #(.N(WIDTH)) u_abs_a (.val(op_a), .neg(a_neg), .res(abs_a));
   muldiv_sign_fix #(.N(WIDTH)) u_abs_b (.val(op_b), .neg(b_neg), .res(abs_b));

   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH-1:0]   div_diff;
   logic               div_ge;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;

   assign mul_sum   = {1'b0, acc} + (qreg[0] ? {1'b0, mcand} : '0);
   assign div_shift = {acc, qreg[WIDTH-1]};
   assign div_ge    = (div_shift >= {1'b0, mcand});
   // when div_ge holds the true difference is below the divisor, so WIDTH bits suffice
   assign div_diff  = div_shift[WIDTH-1:0] - mcand;

   muldiv_sign_fix #(.N(2*WIDTH)) u_fix_prod (.val({acc, qreg}), .neg(neg_res), .res(prod_fix));
   muldiv_sign_fix #(.N(WIDTH))   u_fix_quo  (.val(qreg),        .neg(neg_res), .res(quo_fix));
   muldiv_sign_fix #(.N(WIDTH))   u_fix_rem  (.val(acc),         .neg(neg_rem), .res(rem_fix));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (start_mul)      state_nxt = ST_MUL;
            else if (start_div) state_nxt = b_zero ? ST_FIX : ST_DIV;
         end
         ST_MUL:  if (last_step) state_nxt = ST_FIX;
         ST_DIV:  if (last_step) state_nxt = ST_FIX;
         ST_FIX:  state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         acc     <= '0;
         qreg    <= '0;
         mcand   <= '0;
         hi_r    <= '0;
         lo_r    <= '0;
         neg_res <= 1'b0;
         neg_rem <= 1'b0;
         is_div  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start_mul) begin
                  cnt     <= '0;
                  acc     <= '0;
                  qreg    <= abs_b;
                  mcand   <= abs_a;
                  neg_res <= a_neg ^ b_neg;
                  neg_rem <= 1'b0;
                  is_div  <= 1'b0;
               end else if (start_div) begin
                  cnt    <= '0;
                  mcand  <= abs_b;
                  is_div <= 1'b1;
                  // divide-by-zero preloads the final answer and lets FIX pass it through unsigned
                  if (b_zero) begin
                     acc     <= op_a;
                     qreg    <= '1;
                     neg_res <= 1'b0;
                     neg_rem <= 1'b0;
                  end else begin
                     acc     <= '0;
                     qreg    <= abs_a;
                     neg_res <= a_neg ^ b_neg;
                     neg_rem <= a_neg;
                  end
               end
            end
            ST_MUL: begin
               acc  <= mul_sum[WIDTH:1];
               qreg <= {mul_sum[0], qreg[WIDTH-1:1]};
               cnt  <= cnt + CNT_W'(1);
            end
            ST_DIV: begin
               acc  <= div_ge ? div_diff : div_shift[WIDTH-1:0];
               qreg <= {qreg[WIDTH-2:0], div_ge};
               cnt  <= cnt + CNT_W'(1);
            end
            ST_FIX: begin
               if (is_div) begin
                  hi_r <= rem_fix;
                  lo_r <= quo_fix;
               end else begin
                  {hi_r, lo_r} <= prod_fix;
               end
               done_r <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign busy    = (state != ST_IDLE);
   assign stall   = busy && (dec_mul || dec_div || dec_mfhi || dec_mflo);
   assign done    = done_r;
   assign hi      = hi_r;
   assign lo      = lo_r;
   assign mf_data = dec_mfhi ? hi_r : (dec_mflo ? lo_r : '0);

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit at WIDTH 32 and 8
module tb_muldiv_unit;

   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  alu_op;
   logic [5:0]  funct;
   logic [31:0] op_a, op_b;
   logic        busy, stall, done;
   logic [31:0] hi, lo, mf_data;

   logic [1:0]  alu_op8;
   logic [5:0]  funct8;
   logic [7:0]  op_a8, op_b8;
   logic        busy8, stall8, done8;
   logic [7:0]  hi8, lo8, mf_data8;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   muldiv_unit #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .alu_op(alu_op), .funct(funct),
      .op_a(op_a), .op_b(op_b), .busy(busy), .stall(stall), .done(done),
      .hi(hi), .lo(lo), .mf_data(mf_data)
   );

   muldiv_unit #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .alu_op(alu_op8), .funct(funct8),
      .op_a(op_a8), .op_b(op_b8), .busy(busy8), .stall(stall8), .done(done8),
      .hi(hi8), .lo(lo8), .mf_data(mf_data8)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      alu_op = 2'd2; funct = f; op_a = a; op_b = b;
      @(posedge clk);
      #1;
      alu_op = 2'd0; funct = 6'd0;
   endtask

   task automatic wait_done(input bit narrow, output int cyc);
      cyc = -1;
      for (int i = 1; i <= 100 && cyc < 0; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (narrow ? done8 : done) cyc = i;
      end
   endtask

   task automatic do_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input int ecyc);
      int cyc;
      issue(f, a, b);
      wait_done(1'b0, cyc);
      check({tag, "_cyc"}, cyc, ecyc);
      check({tag, "_hi"}, hi, ehi);
      check({tag, "_lo"}, lo, elo);
   endtask

   task automatic do_op8(input string tag, input logic [5:0] f, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] ehi, input logic [7:0] elo);
      int cyc;
      @(negedge clk);
      alu_op8 = 2'd2; funct8 = f; op_a8 = a; op_b8 = b;
      @(posedge clk);
      #1;
      alu_op8 = 2'd0; funct8 = 6'd0;
      wait_done(1'b1, cyc);
      check({tag, "_cyc"}, cyc, 9);
      check({tag, "_hi"}, hi8, ehi);
      check({tag, "_lo"}, lo8, elo);
   endtask

   initial begin
      int cyc, stalls;
      bit got;
      rst_n = 1'b0;
      alu_op = 2'd0; funct = 6'd0; op_a = '0; op_b = '0;
      alu_op8 = 2'd0; funct8 = 6'd0; op_a8 = '0; op_b8 = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_stall", stall, 0);
      check("rst_hi", hi, 0);
      check("rst_lo", lo, 0);
      rst_n = 1'b1;

      do_op("multu_max", F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33);
      do_op("mult_m7x3", F_MULT, 32'hFFFFFFF9, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFEB, 33);

      @(negedge clk);
      alu_op = 2'd2; funct = F_MFHI;
      #1 check("mfhi_data", mf_data, 32'hFFFFFFFF);
      check("mfhi_nostall", stall, 0);
      funct = F_MFLO;
      #1 check("mflo_data", mf_data, 32'hFFFFFFEB);
      alu_op = 2'd1;
      #1 check("mflo_nonrtype", mf_data, 0);
      alu_op = 2'd2; funct = 6'b100000;
      #1 check("mf_other_funct", mf_data, 0);
      alu_op = 2'd1; funct = F_MULT; op_a = 32'd2; op_b = 32'd2;
      @(posedge clk);
      @(negedge clk);
      check("mult_nonrtype_ignored", busy, 0);
      alu_op = 2'd0; funct = 6'd0;

      do_op("div_m7d2", F_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33);
      do_op("divu_7d0", F_DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF, 1);
      do_op("div_minneg", F_DIV, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 33);
      do_op("divu_100d7", F_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 33);

      // mflo while busy, with a competing mult presented mid-operation
      issue(F_MULT, 32'd5, 32'd6);
      alu_op = 2'd2; funct = F_MULT; op_a = 32'd100; op_b = 32'd100;
      @(negedge clk);
      check("busy_after_accept", busy, 1);
      check("stall_mult_busy", stall, 1);
      @(posedge clk);
      #1 funct = F_MFLO;
      stalls = 0; got = 0; cyc = -1;
      for (int i = 1; i <= 100 && !got; i++) begin
         @(negedge clk);
         if (done) begin
            got = 1;
            cyc = i;
         end else if (stall) begin
            stalls++;
         end
         if (!got) @(posedge clk);
      end
      check("mflo_wait_cyc", cyc, 33);
      check("mflo_stall_cycles", stalls, 32);
      check("mflo_stall_released", stall, 0);
      check("mflo_new_lo", mf_data, 32'd30);
      check("mult5x6_hi", hi, 0);
      alu_op = 2'd0; funct = 6'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("second_mult_ignored", busy, 0);
      check("lo_held", lo, 32'd30);

      // asynchronous reset in the middle of a divide
      issue(F_DIV, 32'd100, 32'd7);
      repeat (10) @(posedge clk);
      check("div_midway_busy", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_hi", hi, 0);
      check("midrst_lo", lo, 0);
      check("midrst_done", done, 0);
      @(negedge clk);
      rst_n = 1'b1;
      alu_op = 2'd2; funct = F_MULT; op_a = 32'd12; op_b = 32'hFFFFFFFB;
      @(posedge clk);
      #1 alu_op = 2'd0; funct = 6'd0;
      wait_done(1'b0, cyc);
      check("postrst_cyc", cyc, 33);
      check("postrst_hi", hi, 32'hFFFFFFFF);
      check("postrst_lo", lo, 32'hFFFFFFC4);

      do_op8("w8_mult_80xff", F_MULT, 8'h80, 8'hFF, 8'h00, 8'h80);
      @(negedge clk);
      alu_op8 = 2'd2; funct8 = F_MFLO;
      #1 check("w8_mflo", mf_data8, 8'h80);
      check("w8_nostall", stall8, 0);
      alu_op8 = 2'd0; funct8 = 6'd0;
      do_op8("w8_mult_80x80", F_MULT, 8'h80, 8'h80, 8'h40, 8'h00);
      do_op8("w8_divu_200d7", F_DIVU, 8'd200, 8'd7, 8'd4, 8'd28);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand, HI and LO width; legal values 8..64.
REQ-002 SHALL have parameter CNT_W, default $clog2(WIDTH)+1: iteration counter width.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port alu_op, input, 2 bits: main-decoder op class; 2 selects R-type funct decode.
REQ-006 SHALL have port funct, input, 6 bits: R-type function field.
REQ-007 SHALL have port op_a, input, WIDTH bits: rs value (multiplicand/dividend).
REQ-008 SHALL have port op_b, input, WIDTH bits: rt value (multiplier/divisor).
REQ-009 SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-010 SHALL have port stall, output, 1 bit: pipeline-freeze request to the hazard unit.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse when HI/LO update.
REQ-012 SHALL have port hi, output, WIDTH bits: HI register.
REQ-013 SHALL have port lo, output, WIDTH bits: LO register.
REQ-014 SHALL have port mf_data, output, WIDTH bits: mfhi/mflo read data, combinational from hi/lo.

Function
REQ-015 SHALL decode, only when alu_op==2: mult 011000, multu 011001, div 011010, divu 011011, mfhi 010000, mflo 010010; all other funct/alu_op values SHALL be ignored.
REQ-016 SHALL implement FSM states IDLE, MUL, DIV, FIX; a start is accepted only in IDLE.
REQ-017 SHALL, on an accepted mult/multu, latch operand magnitudes (signed forms: absolute value), record result sign, enter MUL.
REQ-018 SHALL, in MUL, perform one shift-add step per cycle for exactly WIDTH cycles, producing a 2*WIDTH-bit product.
REQ-019 SHALL, on an accepted div/divu with op_b!=0, latch magnitudes and enter DIV: one restoring shift-subtract step per cycle for WIDTH cycles.
REQ-020 SHALL, in FIX, apply signs (product negated if signs differ; quotient negated if signs differ; remainder takes dividend sign), write {hi,lo} (mult) or hi=remainder, lo=quotient (div), pulse done, return to IDLE.
REQ-021 SHALL give latency from accept edge to done pulse of WIDTH+1 cycles for mult and div.
REQ-022 SHALL, for div/divu with op_b==0, go directly to FIX: lo=all ones, hi=op_a, done one cycle after accept.
REQ-023 SHALL, for signed most-negative / -1, give lo=most-negative, hi=0, no exception.
REQ-024 SHALL hold busy high from the accept edge through the FIX cycle inclusive.
REQ-025 SHALL assert stall combinationally when busy is high and any decoded mult/div/mfhi/mflo is presented.
REQ-026 SHALL ignore new mult/div requests while busy; hi/lo SHALL change only in FIX.
REQ-027 SHALL drive mf_data=hi for mfhi, lo for mflo, else 0.

Reset
REQ-028 SHALL, on rst_n low at any time including mid-operation, asynchronously force IDLE and clear hi, lo, counter and datapath registers to 0, and drive busy, done and stall to 0.
REQ-029 SHALL accept a new operation on the first rising edge after rst_n deasserts.

Structure
REQ-030 SHALL place funct codes, the ALU_OP_RTYPE constant and the FSM state enum in shared package mips_pkg.
REQ-031 SHALL be one module with an optional sub-module muldiv_sign_fix for abs/negate logic; the counter SHALL be CNT_W bits.

Verification
REQ-032 SHALL check: WIDTH=32, multu 0xFFFFFFFF*0xFFFFFFFF -> done at cycle 33, hi=0xFFFFFFFE, lo=0x00000001.
REQ-033 SHALL check: mult -7*3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-034 SHALL check: div -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu 7/0 -> lo=0xFFFFFFFF, hi=7, done one cycle after accept.
REQ-035 SHALL check: mflo issued while busy -> stall=1 until done, then mf_data=new lo; second mult while busy is ignored.
REQ-036 SHALL check: rst_n pulsed low at cycle 10 of a div -> busy=0, hi=lo=0 immediately; the next mult completes correctly.
REQ-037 SHALL check: WIDTH=8, mult 0x80*0xFF signed -> hi=0x00, lo=0x80, done at cycle 9.
